shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier that consumes the WIDTH-bit sum and carry produced by a ripple-carry add stage, one partial product per clock.
- Sits directly downstream of the carry-ripple adder datapath. Instantiates a WIDTH-bit ripple adder (sum plus carry-out) internally.
- Valid/ready handshakes on input and output. One multiplication in flight at a time.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2 to 16). Product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A and B are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  Product is valid.
- out_ready  input  1  consumer accepts Product.
- Product  output  2*WIDTH  A*B, unsigned.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, Product=0, internal accumulator, counter and operand registers=0.
- rst has priority over every other event. Reset mid-CALC or in DONE aborts the operation. The result is discarded, and the block is in IDLE on the next cycle.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge N: latch mcand<=A, acc_hi<=0, acc_lo<=B, count<=0. Go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge performs one iteration:
    - {c, s} = acc_hi + (acc_lo[0] ? mcand : 0), using the WIDTH-bit ripple add with carry-out.
    - {acc_hi, acc_lo} <= {c, s, acc_lo} >> 1.
    - count <= count+1.
    - On the iteration where count==WIDTH-1: Product <= shifted result, then go to DONE.
  - DONE: out_valid=1, in_ready=0. Product is held stable. On out_valid&out_ready: go to IDLE, out_valid falls on the next cycle.
- Latency: operands accepted at edge N; out_valid is high in the cycle after edge N+WIDTH. With out_ready held high, the next in_ready is high after edge N+WIDTH+1.
- Throughput: at most one result per WIDTH+2 cycles. Input and output phases do not overlap.
- Operands are sampled only at the accept edge. A/B changes during CALC/DONE have no effect.
- Arithmetic:
  - Exact unsigned product.
  - The adder carry-out is kept as bit WIDTH of the shifted accumulator, so no overflow is possible.
  - 0*x and x*0 yield 0.
  - Max case (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Product keeps its last value after the output handshake until the next completion. Its reset value is 0.
- in_valid while not in IDLE is ignored; the operands are not queued.
- out_ready while out_valid=0 has no effect.
- count is ceil(log2(WIDTH+1)) bits and never wraps during an operation.

Test Plan:
- Reset, then hold rst=0 idle: in_ready=1, out_valid=0, Product=0. Then A=0, B=9 -> Product=0 after 5 cycles.
- WIDTH=4, A=13, B=11 accepted at edge N, out_ready=1 -> out_valid high exactly in the cycle after edge N+4 with Product=143. in_ready high again after edge N+5.
- A=15, B=15 with out_ready=0 for 10 cycles after out_valid -> Product=225 held stable, in_ready=0 throughout. Releasing out_ready returns the block to IDLE.
- Assert rst for one cycle at edge N+2 of A=7, B=6 -> out_valid never rises for that operation, and the block is in IDLE the next cycle. A new op A=3, B=5 -> 15.
- in_valid held high with changing operands (2*3, then 9*9) -> results 6 then 81 in order. Operand changes during CALC are ignored.
- WIDTH=8: A=255, B=255 -> Product=65025, 9-cycle latency. A=128, B=2 -> 256.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//   Operand/result bundle for the sequential shift-and-add multiplier.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid and ready are both high. Once valid is raised, the source holds
//   it and its payload steady until that edge. Ready may depend on state only,
//   never on valid.
//
//   Signals
//     in_valid  : operands A/B are valid (master -> slave)
//     in_ready  : multiplier can take operands (slave -> master)
//     A, B      : WIDTH-bit unsigned operands (master -> slave)
//     out_valid : Product is valid (slave -> master)
//     out_ready : consumer accepts Product (master -> slave)
//     Product   : 2*WIDTH-bit unsigned product (slave -> master)
//
//   Modports
//     slave  : the multiplier
//     master : the producer/consumer driving the multiplier
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   Product;

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Product
    );

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned shift-and-add multiplier. One partial product is added
//   per clock through a WIDTH-bit ripple-carry adder; the adder carry-out is
//   kept as the top bit of the shifted accumulator so the product is exact.
//   One multiplication in flight at a time.
//
//   Ports
//     clk         : single clock, rising edge
//     rst         : synchronous, active-high reset (aborts any operation)
//     bus         : operand/result handshake bundle (slave modport)
//     o_dbg_state : current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
//   Timing: operands accepted at edge N, out_valid is high in the cycle after
//   edge N+WIDTH; Product is held until the next completion.
// ---------------------------------------------------------------------------

// WIDTH-bit ripple-carry adder with carry-out (no carry-in).
module shift_add_multiplier_ripple_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_carry = w_c[WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_add_multiplier_if.slave   bus,
    output logic [1:0]              o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_acc_hi;
    logic [WIDTH-1:0]       r_acc_lo;
    logic [CW-1:0]          r_count;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_carry;
    logic                   w_accept;
    logic                   w_last;

    // Partial product: the multiplicand when the current multiplier bit is 1.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    shift_add_multiplier_ripple_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a     (r_acc_hi),
        .i_b     (w_addend),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        w_accept      = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: {acc_hi, acc_lo} holds the running sum above the not yet
    // consumed multiplier bits. Each step adds, then shifts the whole
    // {carry, sum, acc_lo} right by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= bus.A;
            r_acc_hi <= '0;
            r_acc_lo <= bus.B;
            r_count  <= '0;
        end else if (r_state == S_CALC) begin
            r_acc_hi <= {w_carry, w_sum[WIDTH-1:1]};
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
            r_count  <= r_count + CW'(1);
            if (w_last) begin
                r_product <= {w_carry, w_sum, r_acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign bus.Product = r_product;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed vectors against a WIDTH=4 and a WIDTH=8 instance sharing one
//   clock and reset. Expected products are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;
    logic       clk;
    logic       rst;
    logic [1:0] dbg4;
    logic [1:0] dbg8;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [31:0] exp_q[$];

    shift_add_multiplier_if #(.WIDTH(4)) if4 ();
    shift_add_multiplier_if #(.WIDTH(8)) if8 ();

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (if4),
        .o_dbg_state (dbg4)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .bus         (if8),
        .o_dbg_state (dbg8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic f_in_ready(input int sel);
        return (sel == 8) ? if8.in_ready : if4.in_ready;
    endfunction

    function automatic logic f_out_valid(input int sel);
        return (sel == 8) ? if8.out_valid : if4.out_valid;
    endfunction

    function automatic logic [31:0] f_product(input int sel);
        return (sel == 8) ? 32'(if8.Product) : 32'(if4.Product);
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b);
        if (sel == 8) begin
            if8.in_valid = v;
            if8.A        = a[7:0];
            if8.B        = b[7:0];
        end else begin
            if4.in_valid = v;
            if4.A        = a[3:0];
            if4.B        = b[3:0];
        end
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        if (sel == 8) if8.out_ready = r;
        else          if4.out_ready = r;
    endtask

    // One full operation: accept, measure latency, check product, optionally
    // hold out_ready low for hold cycles, then complete the output handshake.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input int hold);
        int  lat;
        bit  bad;
        drive(sel, 1'b1, a, b);
        check("in_ready_before_accept", 32'(f_in_ready(sel)), 32'd1);
        tick();
        // Garbage operands after the accept edge must not disturb the result.
        drive(sel, 1'b0, 16'hFFFF, 16'hFFFF);
        check("in_ready_in_calc", 32'(f_in_ready(sel)), 32'd0);
        lat = 0;
        while (!f_out_valid(sel) && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(sel));
        check("product", f_product(sel), exp);
        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (f_product(sel) !== exp || f_in_ready(sel) !== 1'b0 || f_out_valid(sel) !== 1'b1)
                    bad = 1'b1;
            end
            check("hold_stable", 32'(bad), 32'd0);
        end
        set_out_ready(sel, 1'b1);
        tick();
        check("in_ready_after_release", 32'(f_in_ready(sel)), 32'd1);
        check("out_valid_after_release", 32'(f_out_valid(sel)), 32'd0);
        set_out_ready(sel, 1'b0);
        check("product_kept", f_product(sel), exp);
    endtask

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        int  accepts;
        int  got;
        int  cyc;
        bit  saw_valid;

        rst = 1'b1;
        drive(4, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 16'd0, 16'd0);
        set_out_ready(4, 1'b0);
        set_out_ready(8, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready", 32'(if4.in_ready), 32'd1);
        check("rst_out_valid", 32'(if4.out_valid), 32'd0);
        check("rst_product", 32'(if4.Product), 32'd0);
        check("rst_state", 32'(dbg4), 32'd0);
        check("rst_product_w8", 32'(if8.Product), 32'd0);

        // Zero operand, ordinary case, max case with back-pressure
        run_op(4, 16'd0, 16'd9, 32'd0, 0);
        run_op(4, 16'd13, 16'd11, 32'd143, 0);
        run_op(4, 16'd15, 16'd15, 32'd225, 10);
        run_op(4, 16'd9, 16'd0, 32'd0, 0);

        // Reset in the middle of CALC aborts the operation
        drive(4, 1'b1, 16'd7, 16'd6);
        tick();                          // edge N: accept
        drive(4, 1'b0, 16'd0, 16'd0);
        tick();                          // edge N+1
        rst = 1'b1;
        tick();                          // edge N+2: reset sampled
        rst = 1'b0;
        check("abort_state", 32'(dbg4), 32'd0);
        check("abort_in_ready", 32'(if4.in_ready), 32'd1);
        check("abort_product", 32'(if4.Product), 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        run_op(4, 16'd3, 16'd5, 32'd15, 0);

        // Back-to-back with in_valid held high; results in order
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd81);
        set_out_ready(4, 1'b1);
        drive(4, 1'b1, 16'd2, 16'd3);
        accepts = 0;
        got     = 0;
        cyc     = 0;
        while (got < 2 && cyc < 60) begin
            if (if4.out_valid) begin
                if (exp_q.size() > 0) check("b2b_product", 32'(if4.Product), exp_q.pop_front());
                got++;
            end
            if (if4.in_ready && if4.in_valid) accepts++;
            tick();
            cyc++;
            if (accepts == 1)      drive(4, 1'b1, 16'd9, 16'd9);
            else if (accepts >= 2) drive(4, 1'b0, 16'd0, 16'd0);
        end
        check("b2b_results", 32'(got), 32'd2);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("b2b_idle", 32'(if4.in_ready), 32'd1);
        set_out_ready(4, 1'b0);

        // Wider instance
        run_op(8, 16'd255, 16'd255, 32'd65025, 0);
        run_op(8, 16'd128, 16'd2, 32'd256, 3);
        run_op(8, 16'd1, 16'd200, 32'd200, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
